// File: rtl/ram_dp_clr_pkg.sv
// Shared types and helpers for the dual-port RAM with hardware clear.
package ram_dp_clr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Value written into every bit of the array by the clear sequencer
  localparam bit CLEAR_FILL_BIT = 1'b0;

  function automatic int unsigned calc_num_bytes(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/ram_dp_clr_if.sv
// Request/response bundle for ram_dp_clr: one write port, one read port, ready.
interface ram_dp_clr_if
  import ram_dp_clr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned BYTE_WIDTH    = 8
) ();

  localparam int unsigned NUM_BYTES = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic                     wr_en_i;
  logic [ADDRESS_WIDTH-1:0] wr_addr_i;
  logic [DATA_WIDTH-1:0]    wr_data_i;
  logic [NUM_BYTES-1:0]     wr_be_i;
  logic                     rd_en_i;
  logic [ADDRESS_WIDTH-1:0] rd_addr_i;
  logic [DATA_WIDTH-1:0]    rd_data_o;
  logic                     rd_valid_o;
  logic                     ready_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, wr_be_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, ready_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, wr_be_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, ready_o
  );

endinterface

// File: rtl/ram_dp_clr_clear_ctrl.sv
// Clear sequencer: walks every address once after reset, then parks in READY.
module ram_clear_ctrl
  import ram_dp_clr_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     o_clr_we,
  output logic [ADDRESS_WIDTH-1:0] o_clr_addr,
  output logic                     o_ready
);

  localparam int unsigned CNT_W    = ADDRESS_WIDTH + 1;
  localparam int unsigned MEM_SIZE = 1 << ADDRESS_WIDTH;

  clr_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;

  // One zero write per cycle; the last address written moves to READY
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MEM_SIZE - 1)) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          r_state <= READY;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_cnt[ADDRESS_WIDTH-1:0];
  assign o_ready    = r_ready;

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM with byte enables, registered read and post-reset clear.
// Define RAM_DP_CLR_WR_FIRST_EN for write-first same-address collisions (default read-first).
module ram_dp_clr
  import ram_dp_clr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned BYTE_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_dp_clr_if.slave bus
);

  localparam int unsigned NUM_BYTES = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned MEM_SIZE  = 1 << ADDRESS_WIDTH;

  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("ram_dp_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  logic                     w_clr_we;
  logic [ADDRESS_WIDTH-1:0] w_clr_addr;
  logic                     w_ready;
  logic                     w_user_wr;
  logic                     w_user_rd;
  logic                     w_we;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [NUM_BYTES-1:0]     w_be;
  logic [DATA_WIDTH-1:0]    w_rd_word;

  logic [DATA_WIDTH-1:0]    r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0]    r_rd_data;
  logic                     r_rd_valid;

  ram_clear_ctrl #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  assign w_user_wr = w_ready & bus.wr_en_i;
  assign w_user_rd = w_ready & bus.rd_en_i;
  assign w_we      = rst_n & (w_clr_we | w_user_wr);

  // Clear sequencer owns the write port until ready
  always_comb begin
    w_addr = bus.wr_addr_i;
    w_data = bus.wr_data_i;
    w_be   = bus.wr_be_i;
    if (w_clr_we) begin
      w_addr = w_clr_addr;
      w_data = {DATA_WIDTH{CLEAR_FILL_BIT}};
      w_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < int'(NUM_BYTES); k++) begin
        if (w_be[k]) begin
          r_mem[w_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= w_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = r_mem[bus.rd_addr_i];
`ifdef RAM_DP_CLR_WR_FIRST_EN
    if (w_user_wr && (bus.wr_addr_i == bus.rd_addr_i)) begin
      for (int k = 0; k < int'(NUM_BYTES); k++) begin
        if (bus.wr_be_i[k]) begin
          w_rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
`endif
  end

  // Read data holds between accepted reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_user_rd;
      if (w_user_rd) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign bus.rd_data_o  = r_rd_data;
  assign bus.rd_valid_o = r_rd_valid;
  assign bus.ready_o    = w_ready;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr with a 16-word array and a word-level reference model.
module tb_ram_dp_clr;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst_n;

  ram_dp_clr_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYTE_WIDTH(BW)) bus ();

  ram_dp_clr #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYTE_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            mdl_ready = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [3:0] be);
    logic [DW-1:0] m;
    m = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) m[k*8 +: 8] = new_w[k*8 +: 8];
    return m;
  endfunction

  // Monitor: compares every presented read against the scoreboard, and checks hold/reset values
  initial begin : monitor
    bit            rst_seen;
    logic [DW-1:0] hold;
    logic [DW-1:0] e;
    hold = '0;
    forever begin
      @(posedge clk);
      rst_seen = rst_n;
      @(negedge clk);
      if (!rst_seen) begin
        check("reset_rd_valid", DW'(bus.rd_valid_o), DW'(0));
        check("reset_rd_data", bus.rd_data_o, DW'(0));
        hold = '0;
      end else if (bus.rd_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 with data %h expected no read", bus.rd_data_o);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", bus.rd_data_o, e);
          hold = e;
        end
      end else begin
        check("rd_data_hold", bus.rd_data_o, hold);
      end
    end
  end

  task automatic idle_inputs();
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    bus.wr_be_i   = '0;
    bus.rd_en_i   = 1'b0;
    bus.rd_addr_i = '0;
  endtask

  // One request cycle; reference model applies the collision rule for this build
  task automatic op(input bit we, input int wa, input logic [DW-1:0] wd, input logic [3:0] be,
                    input bit re, input int ra);
    bus.wr_en_i   = we;
    bus.wr_addr_i = AW'(wa);
    bus.wr_data_i = wd;
    bus.wr_be_i   = be;
    bus.rd_en_i   = re;
    bus.rd_addr_i = AW'(ra);
    if (mdl_ready) begin
`ifdef RAM_DP_CLR_WR_FIRST_EN
      if (we) model[wa] = merge(model[wa], wd, be);
      if (re) exp_q.push_back(model[ra]);
`else
      if (re) exp_q.push_back(model[ra]);
      if (we) model[wa] = merge(model[wa], wd, be);
`endif
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    mdl_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", DW'(bus.ready_o), DW'(0));
    rst_n = 1'b1;
  endtask

  // Counts clear cycles; abort_at>0 returns early so the caller can re-reset
  task automatic clear_wait(input bit poke, input int abort_at);
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if (poke) begin
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = AW'(2);
        bus.wr_data_i = 32'h0000_00FF;
        bus.wr_be_i   = 4'hF;
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = AW'($urandom_range(0, DEPTH - 1));
      end
      @(posedge clk); #1;
      if (abort_at == k) begin
        idle_inputs();
        return;
      end
      check($sformatf("clear_ready_k%0d", k), DW'(bus.ready_o), DW'(k == int'(DEPTH)));
    end
    idle_inputs();
    for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;
    mdl_ready = 1'b1;
  endtask

  initial begin : stimulus
    int waited;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    clear_wait(1'b0, 0);

    for (int a = 0; a < int'(DEPTH); a++) op(0, 0, '0, 4'h0, 1, a);

    op(1, 3, 32'hDEADBEEF, 4'hF, 0, 0);
    op(0, 0, '0, 4'h0, 1, 3);
    op(1, 3, 32'h11223344, 4'h5, 0, 0);
    op(0, 0, '0, 4'h0, 1, 3);
    op(1, 3, 32'hCAFEF00D, 4'h0, 0, 0);
    op(0, 0, '0, 4'h0, 1, 3);

    op(1, 5, 32'hAAAA5555, 4'hF, 0, 0);
    op(1, 5, 32'h12345678, 4'hF, 1, 5);
    op(0, 0, '0, 4'h0, 1, 5);
    op(1, 6, 32'h0BADCAFE, 4'h6, 1, 6);
    op(1, 7, 32'h01020304, 4'hF, 1, 8);
    op(0, 0, '0, 4'h0, 1, 6);

    // Requests during clear must be dropped
    do_reset();
    clear_wait(1'b1, 0);
    op(0, 0, '0, 4'h0, 1, 2);

    // Reset mid-clear restarts the full sequence
    op(1, 15, 32'h5A5A_A5A5, 4'hF, 0, 0);
    do_reset();
    clear_wait(1'b0, 7);
    do_reset();
    clear_wait(1'b0, 0);
    op(0, 0, '0, 4'h0, 1, 15);

    for (int i = 0; i < 400; i++) begin
      op(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), DW'($urandom),
         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    @(negedge clk); #1;
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, both on a single clock.
- Adds per-byte write enables, a registered read with a valid flag, and a hardware clear sequencer that zeroes the whole array after every reset.
- Used as generic buffer storage in the datapath. The controller starts issuing requests only once ready_o is high.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, 10, address bits; depth MEM_SIZE = 2**ADDRESS_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en_i  in  1  write request.
- wr_addr_i  in  ADDRESS_WIDTH  write address.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_be_i  in  NUM_BYTES  byte enables; bit k covers bits [k*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDRESS_WIDTH  read address.
- rd_data_o  out  DATA_WIDTH  registered read data.
- rd_valid_o  out  1  rd_data_o valid, one cycle after an accepted rd_en_i.
- ready_o  out  1  high when the clear sequence is done and requests are accepted.

Behaviour:
- Reset: one clock only; rst_n is synchronous, active-low, sampled on the rising clk edge. While rst_n=0:
  - rd_data_o=0, rd_valid_o=0, ready_o=0.
  - State = CLEAR, clear counter = 0.
- FSM states CLEAR and READY.
  - CLEAR: each cycle writes all-zero to mem[counter], then counter increments.
  - When counter = MEM_SIZE-1 is written, the next state is READY.
  - ready_o rises exactly MEM_SIZE cycles after the first cycle with rst_n=1.
- READY is terminal. Only reset returns the FSM to CLEAR.
- Reset asserted mid-clear aborts the sequence. The counter restarts from 0 on release.
- While ready_o=0, wr_en_i and rd_en_i are ignored:
  - no array write;
  - rd_valid_o stays 0;
  - rd_data_o holds its value.
- Write (ready_o=1, wr_en_i=1): byte lanes with wr_be_i[k]=1 take wr_data_i; other lanes keep their old contents. wr_be_i=0 is a legal no-op.
- Read (ready_o=1, rd_en_i=1): rd_data_o <= mem[rd_addr_i] on the next edge; rd_valid_o=1 for that one cycle.
  - With rd_en_i=0, rd_valid_o=0 and rd_data_o holds its last value.
  - Back-to-back reads give one result per cycle.
- Read-latency is fixed at 1 cycle. There is no backpressure.
- Simultaneous read and write to different addresses are independent.
- Same-address collision behaviour is set by the optional feature.
- Addresses span the full 0..MEM_SIZE-1 range with no wrap logic. The clear counter is ADDRESS_WIDTH+1 bits wide so the terminal compare is exact.
- Elaboration error if DATA_WIDTH % BYTE_WIDTH != 0.

Optional Feature:
- Macro: RAM_DP_CLR_WR_FIRST_EN.
- Defined: on a same-cycle, same-address read and write, rd_data_o returns the merged new word (enabled lanes from wr_data_i, other lanes from the old contents).
- Undefined: the read returns the old word (read-first). The array is still updated.

Decomposition:
- Package ram_dp_clr_pkg:
  - state typedef {CLEAR, READY};
  - helper function computing NUM_BYTES;
  - constant for the clear fill value (all zeros).
- One sub-module, ram_clear_ctrl: the CLEAR/READY FSM plus the address counter. It outputs clr_we, clr_addr and ready.
- The top level muxes the clear port onto the write port and holds the array plus the read register.

Test Plan:
- Clear timing: ADDRESS_WIDTH=4, release rst_n → ready_o=0 for exactly 16 cycles, then 1. Read addresses 0..15 → all rd_data_o=0x00000000.
- Basic write/read: wr addr 3, data 0xDEADBEEF, be 4'b1111; next cycle rd addr 3 → rd_valid_o=1 one cycle later, rd_data_o=0xDEADBEEF.
- Byte enables: over 0xDEADBEEF at addr 3, write 0x11223344 with be 4'b0101 → read gives 0xDE22BE44. be 4'b0000 → word unchanged.
- Collision: addr 5 holds 0xAAAA5555; same-cycle write 0x12345678 (be 4'b1111) and read addr 5 → rd_data_o=0xAAAA5555 without the macro, 0x12345678 with it. A following read → 0x12345678 in both builds.
- Ignore-while-clearing: assert wr_en_i to addr 2 with 0xFF and rd_en_i during CLEAR → rd_valid_o stays 0. After ready_o, addr 2 reads 0.
- Reset mid-clear: pulse rst_n low at clear counter 7 → ready_o stays 0 for a full 16 cycles after release. A prior write to addr 15 (before the reset) reads back 0.
